// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared state encoding and width helper for the FIFO write arbiter
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } arb_state_t;

    // Index width that stays at least one bit wide for tiny counts
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/fifo_rr_select.sv
// rtl/fifo_rr_select.sv - circular first-set search starting just above a pointer
module fifo_rr_select
    import fifo_arb_pkg::*;
#(
    parameter int C_NUM_PORTS = 4,
    localparam int C_PTR_W    = clog2_min1(C_NUM_PORTS)
) (
    input  logic [C_NUM_PORTS-1:0] i_req,
    input  logic [C_PTR_W-1:0]     i_ptr,
    output logic [C_NUM_PORTS-1:0] o_winner,
    output logic                   o_found
);

    logic [C_NUM_PORTS-1:0] w_winner;
    logic                   w_found;
    logic [C_PTR_W-1:0]     w_idx;

    // The pointer itself is visited last, so the previous owner only wins when alone
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        w_idx    = '0;
        for (int off = 1; off <= C_NUM_PORTS; off++) begin
            w_idx = C_PTR_W'((int'(i_ptr) + off) % C_NUM_PORTS);
            if (!w_found && i_req[w_idx]) begin
                w_winner[w_idx] = 1'b1;
                w_found         = 1'b1;
            end
        end
    end

    assign o_winner = w_winner;
    assign o_found  = w_found;

endmodule

// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin burst arbiter sharing one FIFO write port
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int C_NUM_PORTS  = 4,
    parameter int C_DATA_WIDTH = 32,
    parameter int C_MAX_BURST  = 4
) (
    input  logic                              aclk,
    input  logic                              aresetn,
    input  logic [C_NUM_PORTS-1:0]            s_valid,
    input  logic [C_NUM_PORTS-1:0]            s_last,
    input  logic [C_NUM_PORTS*C_DATA_WIDTH-1:0] s_data,
    output logic [C_NUM_PORTS-1:0]            s_ready,
    output logic                              m_valid,
    output logic [C_DATA_WIDTH-1:0]           m_data,
    output logic                              m_last,
    input  logic                              m_ready,
    output logic [C_NUM_PORTS-1:0]            grant,
    output logic                              busy
);

    localparam int C_PTR_W = clog2_min1(C_NUM_PORTS);
    localparam int C_CNT_W = $clog2(C_MAX_BURST + 1);
    localparam logic [C_CNT_W-1:0] C_LAST_CNT = C_CNT_W'(C_MAX_BURST - 1);
    localparam logic [C_PTR_W-1:0] C_PTR_RST  = C_PTR_W'(C_NUM_PORTS - 1);

    arb_state_t             r_state, w_state_nxt;
    logic [C_NUM_PORTS-1:0] r_grant, w_grant_nxt;
    logic [C_PTR_W-1:0]     r_rr_ptr, w_rr_ptr_nxt;
    logic [C_CNT_W-1:0]     r_beat_cnt, w_beat_cnt_nxt;

    logic [C_NUM_PORTS-1:0]  w_win_onehot;
    logic                    w_win_found;
    logic [C_PTR_W-1:0]      w_win_idx;
    logic [C_DATA_WIDTH-1:0] w_data_arr [C_NUM_PORTS];
    logic                    w_active;
    logic                    w_handshake;
    logic                    w_burst_end;

    for (genvar i = 0; i < C_NUM_PORTS; i++) begin : g_data_split
        assign w_data_arr[i] = s_data[i*C_DATA_WIDTH +: C_DATA_WIDTH];
    end

    // r_rr_ptr doubles as the granted index while ACTIVE, so one search serves both cases
    fifo_rr_select #(
        .C_NUM_PORTS(C_NUM_PORTS)
    ) u_rr_select (
        .i_req    (s_valid),
        .i_ptr    (r_rr_ptr),
        .o_winner (w_win_onehot),
        .o_found  (w_win_found)
    );

    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < C_NUM_PORTS; i++) begin
            if (w_win_onehot[i]) begin
                w_win_idx = C_PTR_W'(i);
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_rr_ptr   <= C_PTR_RST;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_beat_cnt_nxt = r_beat_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_win_found) begin
                    w_state_nxt    = ST_ACTIVE;
                    w_grant_nxt    = w_win_onehot;
                    w_rr_ptr_nxt   = w_win_idx;
                    w_beat_cnt_nxt = '0;
                end
            end
            ST_ACTIVE: begin
                if (w_burst_end) begin
                    w_beat_cnt_nxt = '0;
                    if (w_win_found) begin
                        w_grant_nxt  = w_win_onehot;
                        w_rr_ptr_nxt = w_win_idx;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_grant_nxt = '0;
                    end
                end else if (w_handshake) begin
                    w_beat_cnt_nxt = r_beat_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_comb begin
        w_active    = (r_state == ST_ACTIVE);
        m_valid     = w_active && s_valid[r_rr_ptr];
        m_last      = w_active && s_last[r_rr_ptr];
        m_data      = w_data_arr[r_rr_ptr];
        s_ready     = r_grant & {C_NUM_PORTS{m_ready}};
        grant       = r_grant;
        busy        = w_active;
        w_handshake = m_valid && m_ready;
        w_burst_end = w_handshake && (s_last[r_rr_ptr] || (r_beat_cnt == C_LAST_CNT));
    end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Round-robin arbiter that shares the write port of one FIFO among C_NUM_PORTS streaming requesters.
- Grants one requester at a time for a burst. A burst ends after C_MAX_BURST beats, or on the requester's last beat, whichever comes first.
- Sits in front of the FIFO write side. Its m_* side connects to the FIFO's s_axis_valid / s_axis_ready / write data.
- Single clock domain.

Parameters:
- C_NUM_PORTS, 4, number of requesters; legal range 2..16.
- C_DATA_WIDTH, 32, beat data width.
- C_MAX_BURST, 4, maximum beats per grant; must be at least 1.

Ports:
- aclk  in  1  clock; all logic is rising-edge.
- aresetn  in  1  reset, asynchronous assert, active-low.
- s_valid  in  C_NUM_PORTS  per-requester beat valid.
- s_last  in  C_NUM_PORTS  per-requester end-of-packet.
- s_data  in  C_NUM_PORTS*C_DATA_WIDTH  per-requester data; port i occupies bits [i*C_DATA_WIDTH +: C_DATA_WIDTH].
- s_ready  out  C_NUM_PORTS  per-requester ready.
- m_valid  out  1  beat valid toward the FIFO.
- m_data  out  C_DATA_WIDTH  muxed data of the granted port.
- m_last  out  1  s_last of the granted port.
- m_ready  in  1  FIFO ready (FIFO not full).
- grant  out  C_NUM_PORTS  registered one-hot grant; all zero when idle.
- busy  out  1  high while a burst is in progress.

Behaviour:
- Interface: one clock (aclk); reset aresetn is asynchronous and active-low.
- Reset values:
  - state = IDLE, grant = 0, beat_cnt = 0.
  - rr_ptr = C_NUM_PORTS-1, so port 0 wins the first arbitration.
  - All outputs are 0 while aresetn is low: m_valid, s_ready, busy, m_last. m_data is don't-care.
- State IDLE:
  - If any s_valid bit is set, select the first set bit scanning upward (circularly) from rr_ptr+1.
  - Register that port as grant, set rr_ptr to it, clear beat_cnt, go to ACTIVE.
  - Arbitration latency is one cycle: no beat is accepted in the cycle the request is first seen.
- State ACTIVE:
  - m_valid = s_valid[g], m_data = s_data[g], m_last = s_last[g], where g is the granted port.
  - s_ready[g] = m_ready; all other s_ready bits are 0.
  - busy = 1. The path from m_ready to s_ready is combinational.
- Beat counting:
  - A handshake is m_valid && m_ready. Each handshake increments beat_cnt.
  - beat_cnt width is $clog2(C_MAX_BURST+1). It never wraps.
- Burst end: a handshake where s_last[g] = 1 or beat_cnt == C_MAX_BURST-1.
- On burst end:
  - Re-arbitrate in the same cycle, scanning circularly from g+1 over the s_valid values of that cycle.
  - If a winner exists, the next cycle is ACTIVE with the new grant and beat_cnt cleared. Back-to-back, no bubble.
  - The current port may win again only if no other port requests.
  - If no winner exists, go to IDLE and set grant to 0.
- s_valid[g] low during ACTIVE: the grant is held, nothing is transferred, and beat_cnt is unchanged. There is no timeout.
- m_ready low: the beat is held. Requesters must keep data stable until the handshake.
- C_MAX_BURST = 1: every handshake ends the burst, giving strict per-beat round-robin.
- Requests raised on non-granted ports mid-burst do not pre-empt the burst. They are considered at the burst end.
- Reset asserted mid-burst: the burst is abandoned immediately with no completion beat. After release, arbitration restarts from port 0.
- Throughput: 1 beat/cycle while m_ready and s_valid[g] stay high. There is a one-cycle bubble only on IDLE→ACTIVE.

Decomposition:
- Shared package fifo_arb_pkg contains:
  - state encoding (IDLE=1'b0, ACTIVE=1'b1);
  - a width helper for clog2.
- Sub-module fifo_rr_select (combinational): inputs are the request vector and the pointer; outputs are the one-hot winner and a found flag. It is instantiated once and used for both the IDLE and burst-end arbitration.

Test Plan:
1. Reset, then s_valid=4'b0001 with continuous m_ready. Expect grant=0001 one cycle later, then 4 handshakes, then re-grant to port 0 with no bubble. Check that busy stays high.
2. s_valid=4'b1111, m_ready=1, s_last=0. Expect grant order 0,1,2,3,0. Each burst is exactly 4 beats. m_data matches the granted port's data.
3. Port 2 asserts s_last on its 2nd beat while port 3 is requesting. Expect the burst to end after 2 beats and grant=1000 the next cycle.
4. m_ready held low for 5 cycles mid-burst at beat_cnt=1. Expect m_valid held, no count change, and the burst to complete after m_ready returns.
5. aresetn pulled low asynchronously at beat 2 of port 1's burst. Expect m_valid/s_ready/grant to go to 0 without a clock edge. After release with s_valid=4'b0010, expect grant=0010.
6. C_MAX_BURST=1, s_valid=4'b0101. Expect grants alternating 0,2,0,2, one beat each, no bubbles.
